// File: rtl/popcount_pkg.sv
// Shared types, default sizing and helpers for the popcount frame sequencer.
package popcount_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLICE = 2'd1,
      EMIT  = 2'd2
   } state_e;

   localparam int WORD_W_DEF  = 64;
   localparam int LANE_W_DEF  = 16;
   localparam int CNT_W_DEF   = 16;
   localparam int WCNT_W_DEF  = 16;

   localparam int NS          = WORD_W_DEF / LANE_W_DEF;
   localparam int SLICE_CNT_W = $clog2(LANE_W_DEF) + 1;
   localparam int IDX_W       = (NS > 1) ? $clog2(NS) : 1;

   // Saturating add: result clamps at maxv instead of wrapping.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] maxv);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, maxv}) sat_add = maxv;
      else                  sat_add = s[31:0];
   endfunction

   // Companion flag: the same add would have exceeded maxv.
   function automatic logic sat_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] maxv);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      sat_ovf = (s > {1'b0, maxv});
   endfunction

   // Elaboration guard: the word must split into whole slices.
   function automatic bit words_fit(input int ww, input int lw);
      words_fit = (lw > 0) && ((ww % lw) == 0);
   endfunction

endpackage

// File: rtl/popcount_frame_seq_slice.sv
// Combinational population count of one LANE_W-bit slice.
module popcount_slice #(
   parameter int LANE_W = 16,
   parameter int OUT_W  = $clog2(LANE_W) + 1
) (
   input  logic [LANE_W-1:0] slice_i,
   output logic [OUT_W-1:0]  count_o
);

   // Ripple sum of the individual bits; LANE_W is small so depth stays modest.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < LANE_W; i++)
         count_o = count_o + OUT_W'(slice_i[i]);
   end

endmodule

// File: rtl/popcount_frame_seq.sv
// Frame popcount sequencer: one shared slice counter walks each word LSB slice
// first, accumulating a saturating frame total and word count for a result port.
module popcount_frame_seq
   import popcount_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int LANE_W = LANE_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int WCNT_W = WCNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic [WCNT_W-1:0] out_words,
   output logic              out_sat
);

   localparam int NSL = WORD_W / LANE_W;
   localparam int SCW = $clog2(LANE_W) + 1;
   localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);
   localparam logic [31:0]   CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
   localparam logic [31:0]   WCNT_MAX = 32'((64'd1 << WCNT_W) - 64'd1);

   if (!words_fit(WORD_W, LANE_W)) begin : g_bad_width
      $error("popcount_frame_seq: WORD_W must be a multiple of LANE_W");
   end

   state_e                       state_q;
   logic [NSL-1:0][LANE_W-1:0]   word_q;
   logic                         last_q;
   logic [IW-1:0]                idx_q;
   logic [CNT_W-1:0]             acc_q,  acc_d;
   logic [WCNT_W-1:0]            wcnt_q, wcnt_d;
   logic                         sat_q,  sat_d;
   logic                         out_valid_q, out_sat_q;
   logic [CNT_W-1:0]             out_count_q;
   logic [WCNT_W-1:0]            out_words_q;

   logic [LANE_W-1:0]            slice_bits;
   logic [SCW-1:0]               slice_cnt;
   logic                         last_slice;

   // The single shared counter sees the slice picked by the current index.
   assign slice_bits = word_q[idx_q];

   popcount_slice #(
      .LANE_W (LANE_W),
      .OUT_W  (SCW)
   ) u_slice (
      .slice_i (slice_bits),
      .count_o (slice_cnt)
   );

   assign last_slice = (idx_q == LAST_IDX);

   // Next accumulator / word counter / sticky saturation for a SLICE cycle.
   always_comb begin
      acc_d  = CNT_W'(sat_add(32'(acc_q), 32'(slice_cnt), CNT_MAX));
      wcnt_d = wcnt_q;
      sat_d  = sat_q | sat_ovf(32'(acc_q), 32'(slice_cnt), CNT_MAX);
      if (last_slice) begin
         wcnt_d = WCNT_W'(sat_add(32'(wcnt_q), 32'd1, WCNT_MAX));
         sat_d  = sat_d | sat_ovf(32'(wcnt_q), 32'd1, WCNT_MAX);
      end
   end

   // Accept while idle, or on the final slice of a non-closing word so
   // consecutive words stream at one per NSL cycles.
   assign in_ready = (state_q == IDLE) ||
                     ((state_q == SLICE) && last_slice && !last_q);

   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign out_words = out_words_q;
   assign out_sat   = out_sat_q;

   // Sequencer: load word, walk slices, publish the frame result, wait for handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         acc_q       <= '0;
         wcnt_q      <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         out_words_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  word_q  <= in_data;
                  last_q  <= in_last;
                  idx_q   <= '0;
                  state_q <= SLICE;
               end
            end
            SLICE: begin
               acc_q  <= acc_d;
               wcnt_q <= wcnt_d;
               sat_q  <= sat_d;
               if (last_slice) begin
                  if (last_q) begin
                     state_q     <= EMIT;
                     out_valid_q <= 1'b1;
                     out_count_q <= acc_d;
                     out_words_q <= wcnt_d;
                     out_sat_q   <= sat_d;
                  end else if (in_valid) begin
                     word_q <= in_data;
                     last_q <= in_last;
                     idx_q  <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  wcnt_q      <= '0;
                  sat_q       <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_frame_seq.sv
// Scoreboard bench: the same word stream drives a default-width DUT and an
// 8-bit-count DUT; each has its own expected-result queue and monitor.
module tb_popcount_frame_seq;

   typedef struct {
      int cnt;
      int words;
      bit sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_sat;
   logic [15:0] a_out_count, a_out_words;
   logic        b_in_ready, b_out_valid, b_out_sat;
   logic [7:0]  b_out_count;
   logic [15:0] b_out_words;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t qa[$];
   exp_t qb[$];

   popcount_frame_seq dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_count(a_out_count), .out_words(a_out_words), .out_sat(a_out_sat)
   );

   popcount_frame_seq #(.CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_count(b_out_count), .out_words(b_out_words), .out_sat(b_out_sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected results for both DUTs, hand-derived per frame.
   task automatic push(input int a_cnt, input bit a_sat, input int b_cnt, input bit b_sat,
                       input int words);
      exp_t e;
      e.cnt = a_cnt; e.words = words; e.sat = a_sat; qa.push_back(e);
      e.cnt = b_cnt; e.sat = b_sat; qb.push_back(e);
   endtask

   // Present a word and hold valid until accepted; valid stays high afterwards.
   task automatic send(input logic [63:0] d, input logic l, output int c);
      int n;
      in_valid = 1'b1; in_data = d; in_last = l; n = 0;
      while (1) begin
         @(negedge clk);
         if (a_in_ready) break;
         n++;
         if (n > 40) begin
            total++; bad++;
            $display("FAIL send_timeout: got in_ready=0 for 40 cycles expected 1");
            break;
         end
      end
      @(posedge clk); #1;
      c = cyc;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (a_out_valid) break;
         n++;
         if (n > 60) begin
            total++; bad++;
            $display("FAIL valid_timeout: got out_valid=0 for 60 cycles expected 1");
            break;
         end
      end
   endtask

   task automatic resync();
      @(posedge clk); #1;
   endtask

   // Monitors: pop and compare on every result handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && a_out_valid && out_ready) begin
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected: got result count=%0d expected none", a_out_count);
         end else begin
            e = qa.pop_front();
            chk("a_count", a_out_count, e.cnt);
            chk("a_words", a_out_words, e.words);
            chk("a_sat",   a_out_sat,   e.sat);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b_out_valid && out_ready) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected: got result count=%0d expected none", b_out_count);
         end else begin
            e = qb.pop_front();
            chk("b_count", b_out_count, e.cnt);
            chk("b_words", b_out_words, e.words);
            chk("b_sat",   b_out_sat,   e.sat);
         end
      end
   end

   initial begin
      int c, c1, c2, h, n;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      #2;
      chk("rst_valid", a_out_valid, 0);
      chk("rst_count", a_out_count, 0);
      chk("rst_words", a_out_words, 0);
      chk("rst_sat",   a_out_sat,   0);
      chk("rst_ready", a_in_ready,  1);
      chk("rst_b_ready", b_in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      resync();

      // Single all-ones word; result appears NS edges after the accept edge.
      push(64, 0, 64, 0, 1);
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, c);
      in_valid = 1'b0;
      wait_valid();
      chk("latency", cyc - c, 4);
      chk("emit_ready", a_in_ready, 0);
      resync();

      // Back-to-back: second word taken on the last slice of the first.
      push(65, 0, 65, 0, 2);
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, c1);
      send(64'h0000_0000_0000_0001, 1'b1, c2);
      in_valid = 1'b0;
      chk("b2b_gap", c2 - c1, 4);
      wait_valid();
      resync();

      // MSB slice counted; zero word only bumps the word count.
      push(1, 0, 1, 0, 2);
      send(64'h8000_0000_0000_0000, 1'b0, c);
      send(64'h0, 1'b1, c);
      in_valid = 1'b0;
      wait_valid();
      resync();

      // Five all-ones words: 320 fits 16 bits, clamps to 255 on the 8-bit DUT.
      push(320, 0, 255, 1, 5);
      for (int i = 0; i < 5; i++) send(64'hFFFF_FFFF_FFFF_FFFF, (i == 4), c);
      in_valid = 1'b0;
      wait_valid();
      resync();

      // Sticky saturation cleared by the previous handshake.
      push(4, 0, 4, 0, 1);
      send(64'h0F, 1'b1, c);
      in_valid = 1'b0;
      wait_valid();
      resync();

      // Result backpressure with a new word already waiting; data changed mid-slice.
      out_ready = 1'b0;
      push(4, 0, 4, 0, 1);
      push(1, 0, 1, 0, 1);
      send(64'hF0, 1'b1, c);
      in_data = 64'h1; in_last = 1'b1;
      wait_valid();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_valid", a_out_valid, 1);
         chk("bp_count", a_out_count, 4);
         chk("bp_words", a_out_words, 1);
         chk("bp_ready", a_in_ready, 0);
         chk("bp_b_count", b_out_count, 4);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      h = cyc;
      send(64'h1, 1'b1, c);
      in_valid = 1'b0;
      chk("post_hs_accept", c - h, 2);
      wait_valid();
      resync();

      // Reset during the second slice of a non-closing word.
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, c);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", a_out_valid, 0);
      chk("mid_rst_count", a_out_count, 0);
      chk("mid_rst_words", a_out_words, 0);
      chk("mid_rst_sat",   a_out_sat,   0);
      chk("mid_rst_ready", a_in_ready,  1);
      chk("mid_rst_b_words", b_out_words, 0);
      @(negedge clk);
      rst_n = 1'b1;
      resync();
      push(2, 0, 2, 0, 1);
      send(64'h3, 1'b1, c);
      in_valid = 1'b0;
      wait_valid();
      resync();

      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
